reg_pipe: RTL
=============

# reg_pipe

Parametrised pipeline-delay register with a run-time selectable tap, for operand and result paths in the DSP slice datapath. It replaces the single-stage register/bypass mux with a chain of up to DEPTH registers. A tap select picks the combinational input or the output of any stage. Valid tracking, synchronous flush and an occupancy count let the surrounding control change latency without losing track of in-flight data.

## Interface
- WIDTH, 18, data width in bits (1..48)
- DEPTH, 4, number of register stages in the chain (1..15)
- TW, $clog2(DEPTH+1), tap select width; derived, never overridden
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous assert, active-low, clears all state
- ce  input  1  clock enable; the chain advances only on edges with ce=1
- flush  input  1  synchronous clear of all stages and valid bits
- in_data  input  WIDTH  data into stage 0
- in_valid  input  1  qualifier for in_data
- tap_sel  input  TW  0 = bypass (combinational in_data), k = output of stage k (1..DEPTH)
- out_data  output  WIDTH  selected tap data
- out_valid  output  1  selected tap valid
- occ  output  TW  number of stages currently holding a valid word (0..DEPTH)
- tap_err  output  1  tap_sel > DEPTH this cycle (combinational)

## Operation
- Stages are stage[1..DEPTH] with data and valid bits. stage[1] loads in_data/in_valid. stage[k] loads stage[k-1].
- Edge with rst_n=0: all data = 0, all valid = 0, occ = 0.
- Edge with flush=1: all data = 0, all valid = 0, occ = 0, regardless of ce. flush has priority over ce.
- Edge with ce=1, flush=0: the whole chain shifts by one.
- Edge with ce=0, flush=0: all stages hold; occ holds.
- occ update on a shift: occ_next = occ + in_valid − valid[DEPTH]. occ saturates within 0..DEPTH by construction. A simultaneous entry and exit leaves occ unchanged.
- Output mux is combinational on tap_sel:
  - tap 0: out_data = in_data, out_valid = in_valid.
  - tap k: out_data = stage[k] data, out_valid = stage[k] valid.
- tap_sel > DEPTH: the mux clamps to stage[DEPTH] and tap_err = 1. Chain state is unaffected.
- A tap change mid-stream takes effect immediately. Words beyond the new tap stay in the chain and still count in occ.
- Data is never modified; the block is a pure delay with qualifiers.

## Timing
- Latency of tap k = k ce-qualified rising edges. Edges with ce=0 do not count.
- Tap 0 has zero latency: a purely combinational path from in_data/in_valid to the outputs.
- Reset values: out_data = 0 and out_valid = 0 for taps ≥ 1; occ = 0. tap_err follows tap_sel.
- Deassertion of rst_n is synchronised externally. The first shift happens on the first edge after release with ce=1.
- A flush edge followed by a shift edge loads only the new word into stage[1]. occ = in_valid after the second edge.

## Configuration
- REG_PIPE_OUT_REG_EN defined:
  - An output register (data, valid), reset to 0 and cleared by flush, follows the tap mux.
  - It loads on ce=1 and holds on ce=0.
  - Every tap, including tap 0, gains exactly one ce-qualified cycle of latency.
  - tap_err is also registered. occ is unchanged.
- Undefined: outputs are combinational from the mux as described above.

## Test plan
- Reset and hold:
  - Stimulus: rst_n=0 with in_data=18'h3FFFF, in_valid=1.
  - Response: out_data=0, out_valid=0 at tap 2, occ=0.
  - After release, ce=0 for 5 cycles: outputs stay 0.
- Latency sweep:
  - Stimulus: DEPTH=4, ce=1, feed 1,2,3,… with valid=1 and sweep tap_sel 0..4.
  - Response: out_data equals the input from k edges earlier. occ reaches 4 after 4 edges.
- Stall:
  - Stimulus: tap 3, word 0x155 entered, ce dropped for 3 cycles after 1 edge.
  - Response: 0x155 appears only after 2 further ce=1 edges.
- Flush priority:
  - Stimulus: chain full, flush=1 with ce=1 and in_valid=1.
  - Response: after the edge, all valid=0 and occ=0. The next ce edge gives occ=1.
- Bubbles and occ:
  - Stimulus: valid pattern 1,0,1,1,0 shifted through DEPTH=4.
  - Response: occ sequence 1,1,2,3,2. Tap 4 valid = 1 on edge 4, 0 on edge 5.
- Bad tap:
  - Stimulus: DEPTH=4, tap_sel=7.
  - Response: tap_err=1 and out_data = stage[4]. With REG_PIPE_OUT_REG_EN defined, each scenario shows one extra edge of latency.

Source files
------------

// File: rtl/reg_pipe_if.sv
// Bus interface for reg_pipe: chain control, input word, tap select and tapped outputs.
// TW is derived from DEPTH and is not meant to be overridden.
interface reg_pipe_if #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
);
    localparam int TW = $clog2(DEPTH + 1);

    logic             ce;
    logic             flush;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic [TW-1:0]    tap_sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [TW-1:0]    occ;
    logic             tap_err;

    modport master (
        output ce, flush, in_data, in_valid, tap_sel,
        input  out_data, out_valid, occ, tap_err
    );

    modport slave (
        input  ce, flush, in_data, in_valid, tap_sel,
        output out_data, out_valid, occ, tap_err
    );
endinterface

// File: rtl/reg_pipe.sv
// Pipeline delay register with run-time tap select, valid tracking, flush and occupancy count.
// Optional output register stage enabled by defining REG_PIPE_OUT_REG_EN.
module reg_pipe #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    reg_pipe_if.slave bus
);
    localparam int TW = $clog2(DEPTH + 1);

    logic [DEPTH:1][WIDTH-1:0] data_q, data_d;
    logic [DEPTH:1]            valid_q, valid_d;
    logic [TW-1:0]             occ_q, occ_d;

    logic [WIDTH-1:0] mux_data;
    logic             mux_valid;
    logic             mux_err;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        occ_d   = occ_q;
        if (bus.flush) begin
            data_d  = '0;
            valid_d = '0;
            occ_d   = '0;
        end else if (bus.ce) begin
            data_d[1]  = bus.in_data;
            valid_d[1] = bus.in_valid;
            for (int k = 2; k <= DEPTH; k++) begin
                data_d[k]  = data_q[k-1];
                valid_d[k] = valid_q[k-1];
            end
            // One word in, the oldest word out: the count can never leave 0..DEPTH.
            occ_d = occ_q + TW'(bus.in_valid) - TW'(valid_q[DEPTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    // Out-of-range taps clamp to the last stage and raise tap_err.
    always_comb begin
        mux_err   = (bus.tap_sel > TW'(DEPTH));
        mux_data  = data_q[DEPTH];
        mux_valid = valid_q[DEPTH];
        if (bus.tap_sel == '0) begin
            mux_data  = bus.in_data;
            mux_valid = bus.in_valid;
        end else begin
            for (int k = 1; k <= DEPTH; k++) begin
                if (bus.tap_sel == TW'(k)) begin
                    mux_data  = data_q[k];
                    mux_valid = valid_q[k];
                end
            end
        end
    end

    assign bus.occ = occ_q;

`ifdef REG_PIPE_OUT_REG_EN
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             tap_err_q, tap_err_d;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        tap_err_d   = tap_err_q;
        if (bus.flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            tap_err_d   = 1'b0;
        end else if (bus.ce) begin
            out_data_d  = mux_data;
            out_valid_d = mux_valid;
            tap_err_d   = mux_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            tap_err_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            tap_err_q   <= tap_err_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.tap_err   = tap_err_q;
`else
    assign bus.out_data  = mux_data;
    assign bus.out_valid = mux_valid;
    assign bus.tap_err   = mux_err;
`endif
endmodule
